// File: rtl/led_fade_sequencer_if.sv
// Control and status bundle between the fade sequencer and whoever drives it.
// The master side issues start/stop and the profile settings; the slave side
// (the sequencer) returns the brightness value and its status pulses.
interface led_fade_sequencer_if #(
  parameter int DUTY_WIDTH = 8
);

  logic                  start;
  logic                  stop;
  logic                  loop;
  logic [DUTY_WIDTH-1:0] step;
  logic [DUTY_WIDTH-1:0] duty;
  logic                  duty_update;
  logic                  busy;
  logic                  cycle_done;

  modport master (
    output start,
    output stop,
    output loop,
    output step,
    input  duty,
    input  duty_update,
    input  busy,
    input  cycle_done
  );

  modport slave (
    input  start,
    input  stop,
    input  loop,
    input  step,
    output duty,
    output duty_update,
    output busy,
    output cycle_done
  );

endinterface

// File: rtl/led_fade_sequencer.sv
// Breathing-profile brightness generator feeding the LED PWM comparator.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; prescaler frozen, duty parked at 0
// RAMP_UP   | duty climbs by the latched step each tick, saturating at max
// HOLD_HIGH | duty held at full scale for HOLD_TICKS ticks
// RAMP_DOWN | duty falls by the latched step each tick, saturating at 0
// HOLD_LOW  | duty held at 0 for HOLD_TICKS ticks, then loop or finish
//
// All outputs are registered, so nothing on the interface has a
// combinational path from start/stop/step/loop.
module led_fade_sequencer #(
  parameter int DUTY_WIDTH = 8,
  parameter int PRESCALE   = 2048,
  parameter int HOLD_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  led_fade_sequencer_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [DUTY_WIDTH-1:0] DUTY_MAX   = '1;
  localparam logic [DUTY_WIDTH-1:0] DUTY_ZERO  = '0;
  localparam logic [DUTY_WIDTH-1:0] STEP_ONE   = DUTY_WIDTH'(1);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [HW-1:0]         HOLD_LAST  = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t                state_q,  state_d;
  logic [DUTY_WIDTH-1:0] duty_q,   duty_d;
  logic                  update_q, update_d;
  logic                  done_q,   done_d;
  logic                  busy_q,   busy_d;
  logic [PW-1:0]         presc_q,  presc_d;
  logic [HW-1:0]         hold_q,   hold_d;
  logic [DUTY_WIDTH-1:0] step_q,   step_d;
  logic                  loop_q,   loop_d;

  logic                  tick;
  logic [DUTY_WIDTH:0]   up_sum;
  logic [DUTY_WIDTH-1:0] up_val;
  logic [DUTY_WIDTH-1:0] down_val;
  logic                  hold_last;

  // Tick strobe and the saturating next-duty candidates for both ramp directions.
  always_comb begin
    tick      = (state_q != IDLE) && (presc_q == PRESC_LAST);
    hold_last = (hold_q == HOLD_LAST);
    // One extra bit catches the carry so the ramp pins at full scale instead of wrapping.
    up_sum    = {1'b0, duty_q} + {1'b0, step_q};
    up_val    = up_sum[DUTY_WIDTH] ? DUTY_MAX : up_sum[DUTY_WIDTH-1:0];
    down_val  = (step_q >= duty_q) ? DUTY_ZERO : (duty_q - step_q);
  end

  // Next-state, datapath and output decode for the profile sequencer.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    update_d = 1'b0;
    done_d   = 1'b0;
    presc_d  = presc_q;
    hold_d   = hold_q;
    step_d   = step_q;
    loop_d   = loop_q;

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : (presc_q + 1'b1);
    end

    case (state_q)
      IDLE: begin
        // stop has priority, so start+stop together leaves the block parked.
        if (bus.start && !bus.stop) begin
          step_d  = (bus.step == DUTY_ZERO) ? STEP_ONE : bus.step;
          loop_d  = bus.loop;
          presc_d = '0;
          state_d = RAMP_UP;
        end
      end

      RAMP_UP: begin
        // A stop here turns the profile around without touching duty on this edge.
        if (bus.stop) begin
          loop_d  = 1'b0;
          state_d = RAMP_DOWN;
        end else if (tick) begin
          duty_d   = up_val;
          update_d = (up_val != duty_q);
          if (up_val == DUTY_MAX) begin
            hold_d  = '0;
            state_d = HOLD_HIGH;
          end
        end
      end

      HOLD_HIGH: begin
        if (bus.stop) begin
          loop_d  = 1'b0;
          state_d = RAMP_DOWN;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_last) begin
            state_d = RAMP_DOWN;
          end
        end
      end

      RAMP_DOWN: begin
        // Already fading out: stop only cancels any further repetition.
        if (bus.stop) begin
          loop_d = 1'b0;
        end
        if (tick) begin
          duty_d   = down_val;
          update_d = (down_val != duty_q);
          if (down_val == DUTY_ZERO) begin
            hold_d  = '0;
            state_d = HOLD_LOW;
          end
        end
      end

      HOLD_LOW: begin
        if (bus.stop) begin
          loop_d = 1'b0;
        end
        if (tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_last) begin
            done_d  = 1'b1;
            state_d = (loop_q && !bus.stop) ? RAMP_UP : IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; async reset drops everything to the parked state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      presc_q  <= '0;
      hold_q   <= '0;
      step_q   <= STEP_ONE;
      loop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      update_q <= update_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      step_q   <= step_d;
      loop_q   <= loop_d;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.duty_update = update_q;
  assign bus.busy        = busy_q;
  assign bus.cycle_done  = done_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer with a tick-level profile model.
module tb_led_fade_sequencer;

  localparam int DW       = 8;
  localparam int PRESCALE = 4;
  localparam int HOLD     = 2;
  localparam int MAXV     = (1 << DW) - 1;

  logic clk;
  logic rst_n;

  led_fade_sequencer_if #(.DUTY_WIDTH(DW)) bus ();

  led_fade_sequencer #(
    .DUTY_WIDTH(DW),
    .PRESCALE  (PRESCALE),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected per-tick results from the model, and observed per-tick DUT values.
  int exp_duty[$];
  bit exp_upd[$];
  bit exp_done[$];
  bit exp_busy[$];
  int obs_duty[$];
  bit obs_upd[$];
  bit obs_done[$];

  function automatic void push_tick(input int d, input bit u, input bit dn, input bit b);
    exp_duty.push_back(d);
    exp_upd.push_back(u);
    exp_done.push_back(dn);
    exp_busy.push_back(b);
  endfunction

  // Profile model: walks the breathing shape tick by tick using plain saturating
  // arithmetic. stop_tick = n means stop is held for one cycle right after tick n.
  function automatic void gen(input int s_in, input bit lp, input int stop_tick);
    int  s, v, nv, n;
    bit  stopped, keep;
    s    = (s_in == 0) ? 1 : s_in;
    v    = 0;
    n    = 0;
    keep = lp;
    exp_duty.delete();
    exp_upd.delete();
    exp_done.delete();
    exp_busy.delete();
    while (n < 5000) begin
      stopped = 1'b0;
      while (v < MAXV && !stopped) begin
        nv = (v + s > MAXV) ? MAXV : v + s;
        push_tick(nv, nv != v, 1'b0, 1'b1);
        v = nv;
        n++;
        if (n == stop_tick) begin stopped = 1'b1; keep = 1'b0; end
      end
      for (int h = 0; h < HOLD && !stopped; h++) begin
        push_tick(v, 1'b0, 1'b0, 1'b1);
        n++;
        if (n == stop_tick) begin stopped = 1'b1; keep = 1'b0; end
      end
      do begin
        nv = (v > s) ? v - s : 0;
        push_tick(nv, nv != v, 1'b0, 1'b1);
        v = nv;
        n++;
        if (n == stop_tick) keep = 1'b0;
      end while (v > 0);
      for (int h = 1; h <= HOLD; h++) begin
        push_tick(0, 1'b0, h == HOLD, !(h == HOLD && !keep));
        n++;
        if (n == stop_tick && h != HOLD) keep = 1'b0;
      end
      if (!keep) break;
    end
  endfunction

  // Start a profile, then check every cycle against the model. With noise on,
  // start/step/loop are scrambled while busy. With chain on, the idle tail
  // check is skipped so the next profile can start on the very next edge.
  task automatic run_profile(input string name, input int s, input bit lp,
                             input int stop_tick, input bit noise, input bit chain);
    int        total;
    int        k;
    int        prev;
    logic [10:0] act;
    logic [10:0] expv;
    gen(s, lp, stop_tick);
    total = exp_duty.size();
    obs_duty.delete();
    obs_upd.delete();
    obs_done.delete();
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    bus.step  = s[DW-1:0];
    bus.loop  = lp;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.duty !== 8'd0) begin
      errors++;
      $display("FAIL %s start_accept: busy=%b duty=%0d, required busy=1 duty=0",
               name, bus.busy, bus.duty);
    end
    prev = 0;
    for (int c = 1; c <= total * PRESCALE; c++) begin
      @(posedge clk); #1;
      act = {bus.duty, bus.duty_update, bus.cycle_done, bus.busy};
      if (c % PRESCALE == 0) begin
        k    = c / PRESCALE - 1;
        expv = {exp_duty[k][DW-1:0], exp_upd[k], exp_done[k], exp_busy[k]};
        prev = exp_duty[k];
        obs_duty.push_back(int'(bus.duty));
        obs_upd.push_back(bus.duty_update);
        obs_done.push_back(bus.cycle_done);
      end else begin
        expv = {prev[DW-1:0], 1'b0, 1'b0, 1'b1};
      end
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d {duty,upd,done,busy}: got %0d,%b,%b,%b required %0d,%b,%b,%b",
                 name, c, act[10:3], act[2], act[1], act[0],
                 expv[10:3], expv[2], expv[1], expv[0]);
      end
      bus.stop = (stop_tick > 0 && c == stop_tick * PRESCALE);
      if (noise && c < total * PRESCALE) begin
        bus.step  = DW'($urandom);
        bus.loop  = 1'($urandom);
        bus.start = ($urandom_range(0, 5) == 0);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.stop = 1'b0;
    if (!chain) begin
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.duty !== 8'd0 || bus.cycle_done !== 1'b0 ||
            bus.duty_update !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_tail: busy=%b duty=%0d done=%b upd=%b, required all 0",
                   name, bus.busy, bus.duty, bus.cycle_done, bus.duty_update);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.duty !== 8'd0 || bus.busy !== 1'b0 || bus.duty_update !== 1'b0 ||
        bus.cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: duty=%0d busy=%b upd=%b done=%b, required all 0",
               bus.duty, bus.busy, bus.duty_update, bus.cycle_done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Mid-ramp async reset: run to duty=128, then drop rst_n between edges.
    bus.start = 1'b1;
    bus.step  = 8'd64;
    bus.loop  = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2 * PRESCALE) @(posedge clk);
    #1;
    checks++;
    if (bus.duty !== 8'd128 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_duty: duty=%0d busy=%b, required 128 and 1", bus.duty, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.duty !== 8'd0 || bus.busy !== 1'b0 || bus.duty_update !== 1'b0 ||
        bus.cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: duty=%0d busy=%b upd=%b done=%b, required all 0",
               bus.duty, bus.busy, bus.duty_update, bus.cycle_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_oneshot();
    int ref_d[12] = '{64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0, 0};
    run_profile("oneshot64", 64, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= obs_duty.size() || obs_duty[i] != ref_d[i]) begin
        errors++;
        $display("FAIL oneshot_tick%0d duty: got %0d required %0d", i + 1,
                 (i < obs_duty.size()) ? obs_duty[i] : -1, ref_d[i]);
      end
    end
    checks++;
    if (obs_done.size() != 12 || obs_done[11] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_done_tick12: ticks=%0d, required 12 with done on last",
               obs_done.size());
    end
  endtask

  task automatic test_loop();
    int ref_d[7] = '{255, 255, 255, 0, 0, 0, 255};
    run_profile("loop255", 255, 1'b1, 10, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= obs_duty.size() || obs_duty[i] != ref_d[i]) begin
        errors++;
        $display("FAIL loop_tick%0d duty: got %0d required %0d", i + 1,
                 (i < obs_duty.size()) ? obs_duty[i] : -1, ref_d[i]);
      end
    end
    checks++;
    if (obs_done.size() != 12 || obs_done[5] !== 1'b1 || obs_done[11] !== 1'b1) begin
      errors++;
      $display("FAIL loop_done_ticks: ticks=%0d, required 12 with done at ticks 6 and 12",
               obs_done.size());
    end
  endtask

  task automatic test_step_zero();
    int ups;
    run_profile("step0", 0, 1'b0, 0, 1'b0, 1'b0);
    ups = 0;
    foreach (obs_upd[i]) ups += obs_upd[i];
    checks++;
    if (ups != 510) begin
      errors++;
      $display("FAIL step0_update_count: got %0d required 510", ups);
    end
  endtask

  task automatic test_stop_ramp_up();
    int ref_d[6] = '{64, 128, 64, 0, 0, 0};
    run_profile("stop_up", 64, 1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= obs_duty.size() || obs_duty[i] != ref_d[i]) begin
        errors++;
        $display("FAIL stop_up_tick%0d duty: got %0d required %0d", i + 1,
                 (i < obs_duty.size()) ? obs_duty[i] : -1, ref_d[i]);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.step  = 8'd50;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.duty !== 8'd0) begin
        errors++;
        $display("FAIL start_stop_idle: busy=%b duty=%0d, required 0 and 0", bus.busy, bus.duty);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_profile("b2b_first", 96, 1'b0, 0, 1'b1, 1'b1);
    run_profile("b2b_second", 200, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int s, len, st;
    for (int r = 0; r < 3; r++) begin
      s = $urandom_range(1, 255);
      gen(s, 1'b0, 0);
      len = exp_duty.size();
      st  = (r == 0) ? 0 : $urandom_range(1, len - 1);
      run_profile("rand_oneshot", s, 1'b0, st, 1'b1, 1'b0);
    end
    for (int r = 0; r < 2; r++) begin
      s = $urandom_range(8, 255);
      gen(s, 1'b0, 0);
      len = exp_duty.size();
      st  = $urandom_range(1, 2 * len - 1);
      if (st == len) st = len - 1;
      run_profile("rand_loop", s, 1'b1, st, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    bus.step  = '0;
    test_reset();
    test_oneshot();
    test_loop();
    test_step_zero();
    test_stop_ramp_up();
    test_start_stop_idle();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
